fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  - Next-gen forwarding/hazard control for the RV32I pipeline; sits beside ID/EX and drives ALU operand muxes + stall.
//  - Generalised to NUM_SRC operands, NUM_FWD forwarding stages, and a completion bus for long-latency units (mul/div).
//  - Holds a register scoreboard of in-flight long-latency writes; detects load-use, RAW-on-pending and WAW hazards.
// PARAMETERS
//  NUM_SRC    2               source operands checked per instruction
//  NUM_FWD    2               forwarding stages; index 0 = youngest (EX/MEM), NUM_FWD-1 = oldest (MEM/WB)
//  RF_ADDR_W  `RF_ADDR_WIDTH  register address width; scoreboard depth = 2**RF_ADDR_W
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   synchronous active-low reset
//  idRs           in   NUM_SRC*RF_ADDR_W   consumer source regs, packed, src i at [i*RF_ADDR_W +: RF_ADDR_W]
//  idRsUsed       in   NUM_SRC             src i actually read by the consumer
//  issueValid     in   1                   consumer issues into EX this cycle, qualified internally by !stall
//  issueRegWrite  in   1                   issuing instruction writes rd
//  issueLong      in   1                   issuing instruction executes on a long-latency unit
//  issueRd        in   RF_ADDR_W           issuing instruction rd
//  flush          in   1                   squash the current issue; no scoreboard set
//  stageRd        in   NUM_FWD*RF_ADDR_W   rd held in each forwarding stage, packed
//  stageRegWrite  in   NUM_FWD             stage k writes rd
//  stageReady     in   NUM_FWD             stage k result is valid; 0 for a load still in EX/MEM
//  cplValid       in   1                   long-latency unit completes this cycle
//  cplRd          in   RF_ADDR_W           completing destination
//  fwdSel         out  NUM_SRC*FSEL_W      per-src mux select, packed; encodings in package
//  stall          out  1                   hold IF/ID, insert bubble into EX
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pending[] cleared to 0.
//    While rst_n=0, outputs are forced: stall=0, fwdSel=FSEL_RF.
//  - fwdSel/stall are combinational (0-cycle) from inputs + pending[]; pending[] updates at posedge.
//  - Per src i with idRsUsed[i] && rs!=0, evaluate in priority order; first match wins:
//    - 1. youngest stage k with stageRegWrite[k] && stageRd[k]==rs:
//      - stageReady[k]=1 -> sel=FSEL_STG0+k.
//      - stageReady[k]=0 -> stall=1.
//    - 2. cplValid && cplRd==rs -> sel=FSEL_CPL, no stall; same-cycle bypass of a completing result.
//    - 3. pending[rs] -> stall=1.
//    - 4. otherwise -> sel=FSEL_RF.
//  - rs==0 or !idRsUsed[i] -> sel=FSEL_RF; never contributes to stall.
//  - WAW: issueValid && issueRegWrite && issueRd!=0 && pending[issueRd] && !(cplValid && cplRd==issueRd) -> stall=1.
//  - Set: pending[issueRd]<=1 when issueValid && issueRegWrite && issueLong && issueRd!=0 && !stall && !flush.
//  - Clear: pending[cplRd]<=0 when cplValid && cplRd!=0.
//  - Set and clear on the same reg in the same cycle -> set wins; a new producer replaces the old one.
//  - flush suppresses the set only; already-issued long ops still complete and clear their entries.
//  - Completion of a non-pending reg is legal and has no effect.
//  - Reset mid-operation drops all pending entries; a later cplValid for a dropped entry is ignored.
// CONFIGURATION
//  - FWD_STALL_CNT_EN defined:
//    - Adds outputs stallCycles (32) and stallEvents (32), both reset to 0.
//    - stallCycles +1 every cycle stall=1.
//    - stallEvents +1 on each rising edge of stall.
//    - Both counters saturate at 32'hFFFF_FFFF; no wrap.
//  - FWD_STALL_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Package fwd_pkg:
//    - FSEL_W = $clog2(NUM_FWD+2).
//    - Encodings: FSEL_RF=0, FSEL_STG0=1 .. FSEL_STG0+NUM_FWD-1, FSEL_CPL=NUM_FWD+1.
//    - typedef fsel_t.
//  - Sub-module fwd_scoreboard:
//    - Owns pending[], set/clear/priority logic.
//    - Outputs: pending vector, completion-match flags.
//  - Top: per-src priority mux (generate over NUM_SRC) + WAW/stall OR-reduce + optional counters.
// TESTING
//  1. EX/MEM rd=5 ready, MEM/WB rd=5 ready, rs1=5 -> fwdSel[0]=FSEL_STG0, stall=0 (youngest wins).
//  2. Load in stage0 rd=7, stageReady[0]=0, rs2=7 -> stall=1.
//     Next cycle: load in stage1 with ready=1 -> fwdSel[1]=FSEL_STG0+1, stall=0.
//  3. Long op issues rd=9 -> pending[9]=1.
//     Consumer rs1=9 stalls each cycle until cplValid/cplRd=9 -> that cycle fwdSel[0]=FSEL_CPL, stall=0; pending[9]=0 after.
//  4. pending[3]=1; issue writing rd=3 -> stall=1 (WAW).
//     Same with cplValid/cplRd=3 that cycle -> no stall; pending[3] stays 1 from the new set.
//  5. Issue long rd=4 with flush=1 -> pending[4]=0.
//     Reset while pending[6]=1 -> pending[6]=0; rs=0 with stage rd=0 writing -> FSEL_RF, no stall.
//  6. With FWD_STALL_CNT_EN, 3 stalls of 2 cycles each -> stallCycles=6, stallEvents=3.
//     Preload 32'hFFFF_FFFF then stall once -> value holds.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and mux-select encodings for the forwarding/hazard unit.
// RF_ADDR_WIDTH may be overridden on the command line; it defaults to 5 (RV32I).
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

package fwd_pkg;
    localparam int FWD_STAGES = 2;
    localparam int FSEL_W     = $clog2(FWD_STAGES + 2);

    typedef logic [FSEL_W-1:0] fsel_t;

    localparam fsel_t FSEL_RF   = fsel_t'(0);
    localparam fsel_t FSEL_STG0 = fsel_t'(1);
    localparam fsel_t FSEL_CPL  = fsel_t'(FWD_STAGES + 1);

    function automatic fsel_t fsel_stage(input int k);
        return fsel_t'(int'(FSEL_STG0) + k);
    endfunction
endpackage

// File: rtl/fwd_scoreboard.sv
// Pending-write scoreboard for long-latency producers plus completion-match flags.
// A set and a clear of the same register in one cycle resolves to set.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int RF_ADDR_W = `RF_ADDR_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                set_en,
    input  logic [RF_ADDR_W-1:0]                issue_rd,
    input  logic                                cpl_valid,
    input  logic [RF_ADDR_W-1:0]                cpl_rd,
    input  logic [NUM_SRC-1:0][RF_ADDR_W-1:0]   src_rs,
    output logic [(1<<RF_ADDR_W)-1:0]           pending,
    output logic [NUM_SRC-1:0]                  src_cpl_hit,
    output logic                                issue_cpl_hit
);
    localparam int DEPTH = 1 << RF_ADDR_W;

    logic [DEPTH-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (cpl_valid && cpl_rd != '0) pending_d[cpl_rd] = 1'b0;
        if (set_en)                    pending_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            src_cpl_hit[i] = cpl_valid && (cpl_rd == src_rs[i]);
    end

    assign issue_cpl_hit = cpl_valid && (cpl_rd == issue_rd);
    assign pending       = pending_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and stall generation beside ID/EX.
// Define FWD_STALL_CNT_EN to add saturating stallCycles/stallEvents counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = FWD_STAGES,
    parameter int RF_ADDR_W = `RF_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*RF_ADDR_W-1:0]  idRs,
    input  logic [NUM_SRC-1:0]            idRsUsed,
    input  logic                          issueValid,
    input  logic                          issueRegWrite,
    input  logic                          issueLong,
    input  logic [RF_ADDR_W-1:0]          issueRd,
    input  logic                          flush,
    input  logic [NUM_FWD*RF_ADDR_W-1:0]  stageRd,
    input  logic [NUM_FWD-1:0]            stageRegWrite,
    input  logic [NUM_FWD-1:0]            stageReady,
    input  logic                          cplValid,
    input  logic [RF_ADDR_W-1:0]          cplRd,
    output logic [NUM_SRC*FSEL_W-1:0]     fwdSel,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]                   stallCycles,
    output logic [31:0]                   stallEvents,
`endif
    output logic                          stall
);
    logic [NUM_SRC-1:0][RF_ADDR_W-1:0] src_rs;
    logic [NUM_FWD-1:0][RF_ADDR_W-1:0] stage_rd;
    logic [(1<<RF_ADDR_W)-1:0]         pending;
    logic [NUM_SRC-1:0]                src_cpl_hit;
    logic                              issue_cpl_hit;
    logic [NUM_SRC-1:0][FSEL_W-1:0]    src_sel;
    logic [NUM_SRC-1:0]                src_stall;
    logic                              waw;
    logic                              set_en;

    assign src_rs   = idRs;
    assign stage_rd = stageRd;

    fwd_scoreboard #(.NUM_SRC(NUM_SRC), .RF_ADDR_W(RF_ADDR_W)) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_en        (set_en),
        .issue_rd      (issueRd),
        .cpl_valid     (cplValid),
        .cpl_rd        (cplRd),
        .src_rs        (src_rs),
        .pending       (pending),
        .src_cpl_hit   (src_cpl_hit),
        .issue_cpl_hit (issue_cpl_hit)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fsel_t sel_i;
        logic  stall_i;
        logic  found;

        // Youngest matching stage decides; a not-ready match blocks older sources.
        always_comb begin
            sel_i   = FSEL_RF;
            stall_i = 1'b0;
            found   = 1'b0;
            if (idRsUsed[i] && src_rs[i] != '0) begin
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!found && stageRegWrite[k] && stage_rd[k] == src_rs[i]) begin
                        found = 1'b1;
                        if (stageReady[k]) sel_i   = fsel_stage(k);
                        else               stall_i = 1'b1;
                    end
                end
                if (!found) begin
                    if (src_cpl_hit[i])          sel_i   = FSEL_CPL;
                    else if (pending[src_rs[i]]) stall_i = 1'b1;
                end
            end
        end

        assign src_sel[i]   = sel_i;
        assign src_stall[i] = stall_i;
    end

    assign waw = issueValid && issueRegWrite && issueRd != '0 &&
                 pending[issueRd] && !issue_cpl_hit;

    assign stall  = rst_n && ((|src_stall) || waw);
    assign fwdSel = rst_n ? src_sel : {NUM_SRC{FSEL_RF}};
    assign set_en = issueValid && issueRegWrite && issueLong && issueRd != '0 &&
                    !stall && !flush;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] cycles_q, cycles_d, events_q, events_d;
    logic        stall_prev_q, stall_prev_d;

    always_comb begin
        cycles_d     = cycles_q;
        events_d     = events_q;
        stall_prev_d = stall;
        if (stall && cycles_q != 32'hFFFF_FFFF)                  cycles_d = cycles_q + 32'd1;
        if (stall && !stall_prev_q && events_q != 32'hFFFF_FFFF) events_d = events_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles_q     <= '0;
            events_q     <= '0;
            stall_prev_q <= 1'b0;
        end else begin
            cycles_q     <= cycles_d;
            events_q     <= events_d;
            stall_prev_q <= stall_prev_d;
        end
    end

    assign stallCycles = cycles_q;
    assign stallEvents = events_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed checks of fwd_hazard_unit forwarding priority, stalls and scoreboard.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int NS = 2;
    localparam int NF = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*AW-1:0]  idRs;
    logic [NS-1:0]     idRsUsed;
    logic              issueValid, issueRegWrite, issueLong, flush;
    logic [AW-1:0]     issueRd;
    logic [NF*AW-1:0]  stageRd;
    logic [NF-1:0]     stageRegWrite, stageReady;
    logic              cplValid;
    logic [AW-1:0]     cplRd;
    logic [NS*FSEL_W-1:0] fwdSel;
    logic              stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]       stallCycles, stallEvents;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(NS), .NUM_FWD(NF), .RF_ADDR_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .idRs          (idRs),
        .idRsUsed      (idRsUsed),
        .issueValid    (issueValid),
        .issueRegWrite (issueRegWrite),
        .issueLong     (issueLong),
        .issueRd       (issueRd),
        .flush         (flush),
        .stageRd       (stageRd),
        .stageRegWrite (stageRegWrite),
        .stageReady    (stageReady),
        .cplValid      (cplValid),
        .cplRd         (cplRd),
        .fwdSel        (fwdSel),
`ifdef FWD_STALL_CNT_EN
        .stallCycles   (stallCycles),
        .stallEvents   (stallEvents),
`endif
        .stall         (stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        idRs = '0; idRsUsed = '0;
        issueValid = 0; issueRegWrite = 0; issueLong = 0; issueRd = '0; flush = 0;
        stageRd = '0; stageRegWrite = '0; stageReady = '0;
        cplValid = 0; cplRd = '0;
    endtask

    task automatic src(input int i, input logic [AW-1:0] rs);
        idRs[i*AW +: AW] = rs;
        idRsUsed[i]      = 1'b1;
    endtask

    task automatic stg(input int k, input logic [AW-1:0] rd, input logic rdy);
        stageRd[k*AW +: AW] = rd;
        stageRegWrite[k]    = 1'b1;
        stageReady[k]       = rdy;
    endtask

    task automatic iss(input logic [AW-1:0] rd, input logic lng);
        issueValid = 1; issueRegWrite = 1; issueLong = lng; issueRd = rd;
    endtask

    task automatic cpl(input logic [AW-1:0] rd);
        cplValid = 1; cplRd = rd;
    endtask

    // Inputs change on the falling edge; outputs sampled 1ns later.
    task automatic nxt();
        @(negedge clk);
        clr();
    endtask

    function automatic logic [3:0] sel2(input int s1, input int s0);
        return {2'(s1), 2'(s0)};
    endfunction

    initial begin
        rst_n = 0;
        clr();
        // Outputs forced while in reset even with a hazard presented.
        @(negedge clk);
        src(0, 5); stg(0, 5, 0); iss(6, 1);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel", 32'(fwdSel), 0);
        nxt(); rst_n = 1;
        chk("rst_pend6", 32'(dut.u_sb.pending[6]), 0);

        // Youngest of two matching ready stages wins.
        src(0, 5); stg(0, 5, 1); stg(1, 5, 1); idRs[AW +: AW] = 5;
        #1;
        chk("young_sel", 32'(fwdSel), 32'(sel2(0, 1)));
        chk("young_stall", 32'(stall), 0);

        // Load-use on src1, then load moves to stage1 and is ready.
        nxt(); src(1, 7); stg(0, 7, 0);
        #1;
        chk("ld_stall", 32'(stall), 1);
        nxt(); src(1, 7); stg(1, 7, 1);
        #1;
        chk("ld_sel", 32'(fwdSel), 32'(sel2(2, 0)));
        chk("ld_nostall", 32'(stall), 0);

        // Not-ready younger stage hides a ready older one.
        nxt(); src(0, 12); stg(0, 12, 0); stg(1, 12, 1);
        #1;
        chk("young_notrdy", 32'(stall), 1);

        // Long op rd=9, consumer stalls until completion bypass.
        nxt(); iss(9, 1);
        #1;
        chk("long_iss_stall", 32'(stall), 0);
        nxt();
        chk("pend9_set", 32'(dut.u_sb.pending[9]), 1);
        src(0, 9);
        #1;
        chk("raw_stall0", 32'(stall), 1);
        nxt(); src(0, 9);
        #1;
        chk("raw_stall1", 32'(stall), 1);
        nxt(); src(0, 9); cpl(9);
        #1;
        chk("cpl_sel", 32'(fwdSel), 32'(sel2(0, 3)));
        chk("cpl_nostall", 32'(stall), 0);
        nxt(); src(0, 9);
        #1;
        chk("pend9_clr", 32'(dut.u_sb.pending[9]), 0);
        chk("after_cpl_sel", 32'(fwdSel), 32'(sel2(0, 0)));
        chk("after_cpl_stall", 32'(stall), 0);

        // Stage match outranks a same-cycle completion.
        nxt(); src(1, 8); stg(1, 8, 1); cpl(8);
        #1;
        chk("stg_over_cpl", 32'(fwdSel), 32'(sel2(2, 0)));

        // WAW on pending rd=3, then resolved by same-cycle completion.
        nxt(); iss(3, 1);
        nxt(); iss(3, 0);
        #1;
        chk("waw_stall", 32'(stall), 1);
        nxt(); iss(3, 1); cpl(3);
        #1;
        chk("waw_cpl_nostall", 32'(stall), 0);
        nxt();
        chk("pend3_setwins", 32'(dut.u_sb.pending[3]), 1);
        iss(0, 1);
        #1;
        chk("rd0_nowaw", 32'(stall), 0);
        nxt(); cpl(3);
        nxt();
        chk("pend3_clr", 32'(dut.u_sb.pending[3]), 0);

        // Flushed long issue never sets.
        iss(4, 1); flush = 1;
        nxt(); src(0, 4);
        #1;
        chk("flush_pend4", 32'(dut.u_sb.pending[4]), 0);
        chk("flush_nostall", 32'(stall), 0);

        // Stalled long issue never sets.
        nxt(); iss(10, 1); src(0, 11); stg(0, 11, 0);
        #1;
        chk("stalled_iss", 32'(stall), 1);
        nxt();
        chk("stalled_pend10", 32'(dut.u_sb.pending[10]), 0);

        // Reset drops pending[6]; late completion is harmless.
        iss(6, 1);
        nxt();
        chk("pend6_set", 32'(dut.u_sb.pending[6]), 1);
        rst_n = 0;
        nxt(); rst_n = 1; src(0, 6);
        #1;
        chk("rst_mid_pend6", 32'(dut.u_sb.pending[6]), 0);
        chk("rst_mid_nostall", 32'(stall), 0);
        nxt(); cpl(6); src(1, 13);
        #1;
        chk("cpl_nonpend_sel", 32'(fwdSel), 32'(sel2(0, 0)));
        nxt();
        chk("cpl_nonpend_pend", 32'(dut.u_sb.pending[6]), 0);

        // rs=0 against a writing rd=0 stage, and an unused src.
        src(0, 0); stg(0, 0, 0); idRs[AW +: AW] = 14; stg(1, 14, 0);
        #1;
        chk("x0_sel", 32'(fwdSel), 32'(sel2(0, 0)));
        chk("x0_stall", 32'(stall), 0);

`ifdef FWD_STALL_CNT_EN
        rst_n = 0;
        nxt(); rst_n = 1;
        chk("cnt_rst", stallCycles, 0);
        for (int n = 0; n < 3; n++) begin
            src(0, 15); stg(0, 15, 0);
            nxt(); src(0, 15); stg(0, 15, 0);
            nxt();
            nxt();
        end
        chk("cnt_cycles", stallCycles, 6);
        chk("cnt_events", stallEvents, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
